// File: rtl/rf_wb_arbiter.sv
// Merges ALU and MEM writebacks onto the register file's single write port, with a starvation guard for the ALU.
// Optional macro RF_WB_BYPASS_EN adds byp_* outputs mirroring the registered write for decode forwarding.
module rf_wb_arbiter #(
    parameter int  XLEN         = 64,
    parameter int  NREGS        = 32,
    parameter int  STARVE_LIMIT = 4,
    localparam int AW           = $clog2(NREGS)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            alu_valid_i,
    input  logic [AW-1:0]   alu_rd_i,
    input  logic [XLEN-1:0] alu_data_i,
    output logic            alu_ready_o,
    input  logic            mem_valid_i,
    input  logic [AW-1:0]   mem_rd_i,
    input  logic [XLEN-1:0] mem_data_i,
    output logic            mem_ready_o,
    output logic            rf_we_o,
    output logic [AW-1:0]   rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o
`ifdef RF_WB_BYPASS_EN
    ,
    output logic            byp_valid_o,
    output logic [AW-1:0]   byp_addr_o,
    output logic [XLEN-1:0] byp_data_o
`endif
);

    typedef enum logic [0:0] {
        MEM_PRI = 1'b0,
        ALU_PRI = 1'b1
    } state_e;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_e          state_q, state_d;
    logic [7:0]      starve_q, starve_d;
    logic            alu_gnt_s, mem_gnt_s;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    // Grant selection: the priority source wins whenever it is requesting.
    always_comb begin
        alu_gnt_s = 1'b0;
        mem_gnt_s = 1'b0;
        case (state_q)
            MEM_PRI: begin
                mem_gnt_s = mem_valid_i;
                alu_gnt_s = alu_valid_i & ~mem_valid_i;
            end
            ALU_PRI: begin
                alu_gnt_s = alu_valid_i;
                mem_gnt_s = mem_valid_i & ~alu_valid_i;
            end
            default: begin
                alu_gnt_s = 1'b0;
                mem_gnt_s = 1'b0;
            end
        endcase
    end

    assign alu_ready_o = alu_gnt_s;
    assign mem_ready_o = mem_gnt_s;

    // Starvation tracking: promote the ALU once it has been refused LIMIT cycles in a row.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            MEM_PRI: begin
                if (alu_valid_i && !alu_gnt_s) begin
                    if (starve_q >= (LIMIT - 8'd1)) begin
                        starve_d = LIMIT;
                        state_d  = ALU_PRI;
                    end else begin
                        starve_d = starve_q + 8'd1;
                        state_d  = MEM_PRI;
                    end
                end else begin
                    starve_d = 8'd0;
                    state_d  = MEM_PRI;
                end
            end
            ALU_PRI: begin
                if (alu_gnt_s || !alu_valid_i) begin
                    starve_d = 8'd0;
                    state_d  = MEM_PRI;
                end else begin
                    starve_d = starve_q;
                    state_d  = ALU_PRI;
                end
            end
            default: begin
                starve_d = 8'd0;
                state_d  = MEM_PRI;
            end
        endcase
    end

    // Write-port payload: x0 transfers are consumed but never enable the write.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (alu_gnt_s) begin
            rf_we_d    = (alu_rd_i != {AW{1'b0}});
            rf_waddr_d = alu_rd_i;
            rf_wdata_d = alu_data_i;
        end else if (mem_gnt_s) begin
            rf_we_d    = (mem_rd_i != {AW{1'b0}});
            rf_waddr_d = mem_rd_i;
            rf_wdata_d = mem_data_i;
        end else begin
            rf_we_d    = 1'b0;
            rf_waddr_d = rf_waddr_q;
            rf_wdata_d = rf_wdata_q;
        end
    end

    // State, starvation counter and registered write port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= MEM_PRI;
            starve_q   <= 8'd0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= {AW{1'b0}};
            rf_wdata_q <= {XLEN{1'b0}};
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;

`ifdef RF_WB_BYPASS_EN
    assign byp_valid_o = rf_we_q;
    assign byp_addr_o  = rf_waddr_q;
    assign byp_data_o  = rf_wdata_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized plus directed bench for rf_wb_arbiter, checked against a request-level reference model.
module tb_rf_wb_arbiter;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int LIMIT = 4;

    logic            clk, rst;
    logic            alu_valid_i, mem_valid_i;
    logic [AW-1:0]   alu_rd_i, mem_rd_i;
    logic [XLEN-1:0] alu_data_i, mem_data_i;
    logic            alu_ready_o, mem_ready_o;
    logic            rf_we_o;
    logic [AW-1:0]   rf_waddr_o;
    logic [XLEN-1:0] rf_wdata_o;
`ifdef RF_WB_BYPASS_EN
    logic            byp_valid_o;
    logic [AW-1:0]   byp_addr_o;
    logic [XLEN-1:0] byp_data_o;
`endif

    rf_wb_arbiter #(.XLEN(XLEN), .NREGS(NREGS), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .rst_i(rst),
        .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready_o),
        .mem_valid_i(mem_valid_i), .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i), .mem_ready_o(mem_ready_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o)
`ifdef RF_WB_BYPASS_EN
        , .byp_valid_o(byp_valid_o), .byp_addr_o(byp_addr_o), .byp_data_o(byp_data_o)
`endif
    );

    typedef struct {
        bit              idle;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } req_t;

    req_t alu_q[$];
    req_t mem_q[$];
    bit   alu_pres, mem_pres;

    // Reference model state: what the file port must show and how long the ALU has waited.
    logic            exp_we;
    logic [AW-1:0]   exp_addr;
    logic [XLEN-1:0] exp_data;
    int              refused_m;
    bit              alu_xfer_m, mem_xfer_m;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int obs_addr[$];
    int obs_cyc[$];

    function automatic bit alu_wins(input logic av, input logic mv, input int refused);
        return av && (!mv || refused >= LIMIT);
    endfunction

    function automatic req_t mk(input bit idle, input int rd, input logic [XLEN-1:0] d);
        req_t r;
        r.idle = idle;
        r.rd   = AW'(rd);
        r.data = d;
        return r;
    endfunction

    function automatic req_t rand_req(input int idle_pct);
        req_t r;
        r.idle = ($urandom_range(0, 99) < idle_pct);
        r.rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        r.data = {$urandom, $urandom};
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Model: grant by priority rule, then record the resulting write and the refusal streak.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_we     <= 1'b0;
            exp_addr   <= '0;
            exp_data   <= '0;
            refused_m  <= 0;
            alu_xfer_m <= 1'b0;
            mem_xfer_m <= 1'b0;
        end else begin
            alu_xfer_m <= alu_valid_i && alu_wins(alu_valid_i, mem_valid_i, refused_m);
            mem_xfer_m <= mem_valid_i && !alu_wins(alu_valid_i, mem_valid_i, refused_m);
            if (alu_valid_i && alu_wins(alu_valid_i, mem_valid_i, refused_m)) begin
                exp_we   <= (alu_rd_i != 5'd0);
                exp_addr <= alu_rd_i;
                exp_data <= alu_data_i;
            end else if (mem_valid_i) begin
                exp_we   <= (mem_rd_i != 5'd0);
                exp_addr <= mem_rd_i;
                exp_data <= mem_data_i;
            end else begin
                exp_we <= 1'b0;
            end
            if (alu_valid_i && !alu_wins(alu_valid_i, mem_valid_i, refused_m))
                refused_m <= (refused_m + 1 > LIMIT) ? LIMIT : refused_m + 1;
            else
                refused_m <= 0;
        end
    end

    // Compare process: every cycle out of reset, readies and write port against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("alu_ready", 64'(alu_ready_o), 64'(alu_valid_i && alu_wins(alu_valid_i, mem_valid_i, refused_m)));
            check("mem_ready", 64'(mem_ready_o), 64'(mem_valid_i && !alu_wins(alu_valid_i, mem_valid_i, refused_m)));
            check("rf_we", 64'(rf_we_o), 64'(exp_we));
            check("rf_waddr", 64'(rf_waddr_o), 64'(exp_addr));
            check("rf_wdata", rf_wdata_o, exp_data);
`ifdef RF_WB_BYPASS_EN
            check("byp_valid", 64'(byp_valid_o), 64'(exp_we));
            check("byp_addr", 64'(byp_addr_o), 64'(exp_addr));
            check("byp_data", byp_data_o, exp_data);
`endif
            if (rf_we_o) begin
                obs_addr.push_back(int'(rf_waddr_o));
                obs_cyc.push_back(cyc);
            end
        end
    end

    task automatic present();
        alu_pres = (alu_q.size() > 0);
        mem_pres = (mem_q.size() > 0);
        if (alu_pres) begin
            alu_valid_i = !alu_q[0].idle; alu_rd_i = alu_q[0].rd; alu_data_i = alu_q[0].data;
        end else begin
            alu_valid_i = 1'b0; alu_rd_i = '0; alu_data_i = '0;
        end
        if (mem_pres) begin
            mem_valid_i = !mem_q[0].idle; mem_rd_i = mem_q[0].rd; mem_data_i = mem_q[0].data;
        end else begin
            mem_valid_i = 1'b0; mem_rd_i = '0; mem_data_i = '0;
        end
    endtask

    // One clock: retire what transferred (or idled) last cycle, then present the next heads.
    task automatic tick();
        @(posedge clk);
        #1;
        if (alu_pres && (alu_q[0].idle || alu_xfer_m)) alu_q.delete(0);
        if (mem_pres && (mem_q[0].idle || mem_xfer_m)) mem_q.delete(0);
        present();
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((alu_q.size() > 0 || mem_q.size() > 0) && budget < 300) begin
            tick();
            budget++;
        end
        check("drain_budget", 64'(budget < 300), 64'd1);
        repeat (2) tick();
    endtask

    task automatic check_seq(input string name, input int want[$]);
        check({name, "_len"}, 64'(obs_addr.size()), 64'(want.size()));
        for (int i = 0; i < want.size() && i < obs_addr.size(); i++)
            check(name, 64'(obs_addr[i]), 64'(want[i]));
    endtask

    initial begin
        int want[$];
        rst = 1'b0;
        alu_valid_i = 1'b0; alu_rd_i = '0; alu_data_i = '0;
        mem_valid_i = 1'b0; mem_rd_i = '0; mem_data_i = '0;
        alu_pres = 1'b0; mem_pres = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset_we", 64'(rf_we_o), 64'd0);
        check("reset_waddr", 64'(rf_waddr_o), 64'd0);
        check("reset_wdata", rf_wdata_o, 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;

        // Single ALU write, one cycle of latency.
        alu_q.push_back(mk(1'b0, 5, 64'hDEAD_BEEF));
        tick(); #1;
        check("single_alu_ready", 64'(alu_ready_o), 64'd1);
        check("single_mem_ready", 64'(mem_ready_o), 64'd0);
        tick(); #1;
        check("single_we", 64'(rf_we_o), 64'd1);
        check("single_waddr", 64'(rf_waddr_o), 64'd5);
        check("single_wdata", rf_wdata_o, 64'hDEAD_BEEF);
        tick(); #1;
        check("single_we_after", 64'(rf_we_o), 64'd0);

        // x0 is accepted but never written.
        mem_q.push_back(mk(1'b0, 0, 64'h1234));
        tick(); #1;
        check("x0_mem_ready", 64'(mem_ready_o), 64'd1);
        tick(); #1;
        check("x0_we", 64'(rf_we_o), 64'd0);
        drain();

        // Simultaneous requests: MEM first.
        obs_addr.delete(); obs_cyc.delete();
        mem_q.push_back(mk(1'b0, 3, 64'h33));
        alu_q.push_back(mk(1'b0, 4, 64'h44));
        drain();
        want = {3, 4};
        check_seq("priority_order", want);

        // Starvation: ALU wins after four refusals.
        obs_addr.delete(); obs_cyc.delete();
        for (int r = 1; r <= 8; r++) mem_q.push_back(mk(1'b0, r, 64'(r * 16)));
        alu_q.push_back(mk(1'b0, 9, 64'h99));
        drain();
        want = {1, 2, 3, 4, 9, 5, 6, 7, 8};
        check_seq("starve_order", want);

        // Back-to-back alternating sources.
        obs_addr.delete(); obs_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            alu_q.push_back(mk(1'b0, 10 + i, 64'hA000 + 64'(i)));
            alu_q.push_back(mk(1'b1, 0, 64'h0));
            mem_q.push_back(mk(1'b1, 0, 64'h0));
            mem_q.push_back(mk(1'b0, 20 + i, 64'hB000 + 64'(i)));
        end
        drain();
        want = {10, 20, 11, 21, 12, 22, 13, 23, 14, 24, 15, 25, 16, 26, 17, 27};
        check_seq("b2b_order", want);
        if (obs_cyc.size() == 16)
            check("b2b_span", 64'(obs_cyc[15] - obs_cyc[0]), 64'd15);
        else
            check("b2b_count", 64'(obs_cyc.size()), 64'd16);

        // Reset in the middle of a write while the ALU holds priority.
        for (int i = 0; i < 4; i++) mem_q.push_back(mk(1'b0, 7, 64'h70 + 64'(i)));
        alu_q.push_back(mk(1'b0, 9, 64'h99));
        repeat (5) tick();
        #1;
        check("pre_rst_we", 64'(rf_we_o), 64'd1);
        check("pre_rst_waddr", 64'(rf_waddr_o), 64'd7);
        check("pre_rst_alu_pri", 64'(alu_ready_o), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_we", 64'(rf_we_o), 64'd0);
        check("rst_waddr", 64'(rf_waddr_o), 64'd0);
        check("rst_wdata", rf_wdata_o, 64'd0);
`ifdef RF_WB_BYPASS_EN
        check("rst_byp_valid", 64'(byp_valid_o), 64'd0);
`endif
        alu_q.delete(); mem_q.delete();
        present();
        @(negedge clk);
        #1 rst = 1'b0;
        mem_q.push_back(mk(1'b0, 2, 64'h22));
        alu_q.push_back(mk(1'b0, 3, 64'h33));
        tick(); #1;
        check("post_rst_mem_pri", 64'(mem_ready_o), 64'd1);
        check("post_rst_alu_wait", 64'(alu_ready_o), 64'd0);
        drain();

        // Randomized traffic alternating light and heavy contention.
        for (int i = 0; i < 3000; i++) begin
            if (alu_q.size() < 2) alu_q.push_back(rand_req(((i / 250) % 2 == 1) ? 10 : 50));
            if (mem_q.size() < 2) mem_q.push_back(rand_req(((i / 250) % 2 == 1) ? 5 : 50));
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
